// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel dead-time PWM.
// Channel FSM states, reset defaults and the per-channel duty extractor live here.
package pwm_pkg;

    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_RESOLUTION = 8;
    localparam int DEF_PRESCALE_W = 8;
    localparam int DEF_DEADTIME_W = 4;
    localparam int DEF_DUTY_W     = DEF_RESOLUTION + 1;

    localparam logic [DEF_CHANNELS*DEF_DUTY_W-1:0] DUTY_RESET     = '0;
    localparam logic [DEF_RESOLUTION-1:0]          PERIOD_RESET   = '1;
    localparam logic [DEF_PRESCALE_W-1:0]          PRESCALE_RESET = '0;
    localparam logic [DEF_DEADTIME_W-1:0]          DEADTIME_RESET = '0;

    typedef enum logic [1:0] {
        OFF,
        P_ON,
        N_ON,
        DEAD
    } ch_state_t;

    function automatic logic [DEF_DUTY_W-1:0] duty_of(
        input logic [DEF_CHANNELS*DEF_DUTY_W-1:0] vec,
        input int unsigned                        ch
    );
        return vec[ch*DEF_DUTY_W +: DEF_DUTY_W];
    endfunction

endpackage

// File: rtl/pwm_multi_deadtime_if.sv
// Control/status bundle between the PWM block and whoever programs it.
// master = control side, slave = PWM block.
interface pwm_multi_deadtime_if
    import pwm_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int RESOLUTION = DEF_RESOLUTION,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int DEADTIME_W = DEF_DEADTIME_W
);
    logic                               enable;
    logic                               load;
    logic [RESOLUTION-1:0]              period;
    logic [PRESCALE_W-1:0]              prescale;
    logic [DEADTIME_W-1:0]              deadtime;
    logic [CHANNELS*(RESOLUTION+1)-1:0] duty;
    logic [CHANNELS-1:0]                pwm_p;
    logic [CHANNELS-1:0]                pwm_n;
    logic                               period_start;
    logic                               update_pending;

    modport master (
        output enable, load, period, prescale, deadtime, duty,
        input  pwm_p, pwm_n, period_start, update_pending
    );

    modport slave (
        input  enable, load, period, prescale, deadtime, duty,
        output pwm_p, pwm_n, period_start, update_pending
    );
endinterface

// File: rtl/pwm_deadtime_ch.sv
// One complementary output pair: turns the raw compare into p/n drives
// with a dead band in which both sides are low.
module pwm_deadtime_ch
    import pwm_pkg::*;
#(
    parameter int DEADTIME_W = DEF_DEADTIME_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  raw,
    input  logic [DEADTIME_W-1:0] deadtime,
    output logic                  p,
    output logic                  n
);
    ch_state_t             state_reg;
    logic                  target_reg;   // 1 = heading for the high side
    logic [DEADTIME_W-1:0] timer_reg;
    logic                  p_reg;
    logic                  n_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= OFF;
            target_reg <= 1'b0;
            timer_reg  <= '0;
            p_reg      <= 1'b0;
            n_reg      <= 1'b0;
        end else if (!run) begin
            state_reg <= OFF;
            p_reg     <= 1'b0;
            n_reg     <= 1'b0;
        end else begin
            case (state_reg)
                OFF: begin
                    state_reg  <= DEAD;
                    target_reg <= raw;
                    timer_reg  <= deadtime;
                end
                P_ON: if (!raw) begin
                    p_reg <= 1'b0;
                    if (deadtime == '0) begin
                        state_reg <= N_ON;
                        n_reg     <= 1'b1;
                    end else begin
                        state_reg  <= DEAD;
                        target_reg <= 1'b0;
                        timer_reg  <= deadtime;
                    end
                end
                N_ON: if (raw) begin
                    n_reg <= 1'b0;
                    if (deadtime == '0) begin
                        state_reg <= P_ON;
                        p_reg     <= 1'b1;
                    end else begin
                        state_reg  <= DEAD;
                        target_reg <= 1'b1;
                        timer_reg  <= deadtime;
                    end
                end
                DEAD: begin
                    // A reversal restarts the whole dead band toward the new side.
                    if (raw != target_reg) begin
                        target_reg <= raw;
                        timer_reg  <= deadtime;
                    end else if (timer_reg <= DEADTIME_W'(1)) begin
                        state_reg <= raw ? P_ON : N_ON;
                        p_reg     <= raw;
                        n_reg     <= ~raw;
                    end else begin
                        timer_reg <= timer_reg - DEADTIME_W'(1);
                    end
                end
                default: state_reg <= OFF;
            endcase
        end
    end

    assign p = p_reg;
    assign n = n_reg;
endmodule

// File: rtl/pwm_multi_deadtime.sv
// Multi-channel PWM: shared prescaler and period counter, double-buffered
// settings applied at period boundaries, one dead-time pair per channel.
module pwm_multi_deadtime
    import pwm_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int RESOLUTION = DEF_RESOLUTION,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int DEADTIME_W = DEF_DEADTIME_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_multi_deadtime_if.slave  bus
);
    localparam int DUTY_VEC_W = CHANNELS * (RESOLUTION + 1);

    typedef struct packed {
        logic [DUTY_VEC_W-1:0] duty;
        logic [RESOLUTION-1:0] period;
        logic [PRESCALE_W-1:0] prescale;
        logic [DEADTIME_W-1:0] deadtime;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        duty:     DUTY_VEC_W'(DUTY_RESET),
        period:   RESOLUTION'(PERIOD_RESET),
        prescale: PRESCALE_W'(PRESCALE_RESET),
        deadtime: DEADTIME_W'(DEADTIME_RESET)
    };

    cfg_t                  cfg_in;
    cfg_t                  shadow_reg;
    cfg_t                  active_reg;
    logic [PRESCALE_W-1:0] presc_reg;
    logic [RESOLUTION-1:0] cnt_reg;
    logic                  pending_reg;
    logic                  enable_d_reg;
    logic                  period_start_reg;
    logic                  run;
    logic                  start;
    logic                  tick;
    logic                  wrap;
    logic                  apply;
    logic [CHANNELS-1:0]   raw;
    logic [CHANNELS-1:0]   p_vec;
    logic [CHANNELS-1:0]   n_vec;

    assign cfg_in = '{duty: bus.duty, period: bus.period,
                      prescale: bus.prescale, deadtime: bus.deadtime};

    // The first enabled cycle only applies settings; counting starts the cycle after,
    // so the counter, compares and channel timers all see the new values from count 0.
    assign run   = bus.enable & enable_d_reg;
    assign start = bus.enable & ~enable_d_reg;
    assign tick  = run && (presc_reg == active_reg.prescale);
    assign wrap  = tick && (cnt_reg == active_reg.period);
    assign apply = wrap | start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg       <= CFG_RESET;
            active_reg       <= CFG_RESET;
            presc_reg        <= '0;
            cnt_reg          <= '0;
            pending_reg      <= 1'b0;
            enable_d_reg     <= 1'b0;
            period_start_reg <= 1'b0;
        end else begin
            enable_d_reg     <= bus.enable;
            period_start_reg <= apply;
            if (!run) begin
                presc_reg <= '0;
                cnt_reg   <= '0;
            end else begin
                presc_reg <= tick ? '0 : presc_reg + PRESCALE_W'(1);
                if (wrap)
                    cnt_reg <= '0;
                else if (tick)
                    cnt_reg <= cnt_reg + RESOLUTION'(1);
            end
            if (bus.load)
                shadow_reg <= cfg_in;
            if (bus.load && apply) begin
                active_reg  <= cfg_in;
                pending_reg <= 1'b0;
            end else if (bus.load) begin
                pending_reg <= 1'b1;
            end else if (apply && pending_reg) begin
                active_reg  <= shadow_reg;
                pending_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign raw[gi] = {1'b0, cnt_reg} < duty_of(active_reg.duty, gi);

        pwm_deadtime_ch #(
            .DEADTIME_W (DEADTIME_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .raw      (raw[gi]),
            .deadtime (active_reg.deadtime),
            .p        (p_vec[gi]),
            .n        (n_vec[gi])
        );
    end

    assign bus.pwm_p          = p_vec;
    assign bus.pwm_n          = n_vec;
    assign bus.period_start   = period_start_reg;
    assign bus.update_pending = pending_reg;
endmodule

// File: tb/tb_pwm_multi_deadtime.sv
// Directed and randomized bench for pwm_multi_deadtime; outputs are compared
// every cycle against a period/window model of the PWM behaviour.
module tb_pwm_multi_deadtime;
    import pwm_pkg::*;

    localparam int CH   = 4;
    localparam int RES  = 8;
    localparam int PW   = 8;
    localparam int DW   = 4;
    localparam int DWID = RES + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_multi_deadtime_if #(.CHANNELS(CH), .RESOLUTION(RES), .PRESCALE_W(PW), .DEADTIME_W(DW)) bus ();

    pwm_multi_deadtime #(.CHANNELS(CH), .RESOLUTION(RES), .PRESCALE_W(PW), .DEADTIME_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // stimulus values
    bit s_en = 0, s_load = 0;
    int s_per = 0, s_pre = 0, s_dt = 0;
    int s_duty[CH];

    // reference model: settings, position in the period, per-channel raw history
    int act_duty[CH], sh_duty[CH];
    int act_per, act_pre, act_dt, sh_per, sh_pre, sh_dt;
    bit m_pend, m_en_d, m_ps;
    int m_c;                       // enabled clk cycles since the period began
    int m_streak[CH];              // cycles raw has held its current value
    bit m_last[CH], m_reached[CH], m_p[CH], m_n[CH];

    task automatic chk(input string tag, input int ch, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s ch=%0d t=%0t observed=%0b expected=%0b", tag, ch, $time, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic drive();
        bus.enable   = s_en;
        bus.load     = s_load;
        bus.period   = RES'(s_per);
        bus.prescale = PW'(s_pre);
        bus.deadtime = DW'(s_dt);
        for (int i = 0; i < CH; i++) bus.duty[i*DWID +: DWID] = DWID'(s_duty[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            act_duty[i] = 0; sh_duty[i] = 0;
            m_streak[i] = 0; m_last[i] = 0; m_reached[i] = 0; m_p[i] = 0; m_n[i] = 0;
        end
        act_per = 255; act_pre = 0; act_dt = 0;
        sh_per = 255; sh_pre = 0; sh_dt = 0;
        m_pend = 0; m_en_d = 0; m_ps = 0; m_c = 0;
    endtask

    task automatic model_step();
        bit run, start, wrap, apply, raw;
        int cnt, need;
        run   = s_en && m_en_d;
        start = s_en && !m_en_d;
        cnt   = m_c / (act_pre + 1);
        wrap  = run && (m_c == (act_per + 1) * (act_pre + 1) - 1);
        apply = wrap || start;
        // an output side turns on once raw has been steady for the dead time plus one
        for (int i = 0; i < CH; i++) begin
            raw = (cnt < act_duty[i]);
            if (!run) begin
                m_streak[i] = 0; m_reached[i] = 0; m_p[i] = 0; m_n[i] = 0;
            end else begin
                if (m_streak[i] > 0 && raw == m_last[i]) m_streak[i]++;
                else begin m_streak[i] = 1; m_last[i] = raw; end
                need = (m_reached[i] ? act_dt : (act_dt > 0 ? act_dt : 1)) + 1;
                if (m_streak[i] >= need) begin
                    m_p[i] = raw; m_n[i] = !raw; m_reached[i] = 1;
                end else begin
                    m_p[i] = 0; m_n[i] = 0;
                end
            end
        end
        m_ps = apply;
        m_c  = (!run || wrap) ? 0 : m_c + 1;
        if (s_load) begin
            for (int i = 0; i < CH; i++) sh_duty[i] = s_duty[i];
            sh_per = s_per; sh_pre = s_pre; sh_dt = s_dt;
        end
        if ((s_load && apply) || (!s_load && apply && m_pend)) begin
            for (int i = 0; i < CH; i++) act_duty[i] = sh_duty[i];
            act_per = sh_per; act_pre = sh_pre; act_dt = sh_dt;
            m_pend = 0;
        end else if (s_load) begin
            m_pend = 1;
        end
        m_en_d = s_en;
    endtask

    task automatic check_all();
        for (int i = 0; i < CH; i++) begin
            chk("pwm_p", i, bus.pwm_p[i], m_p[i]);
            chk("pwm_n", i, bus.pwm_n[i], m_n[i]);
            chk("no_overlap", i, bus.pwm_p[i] & bus.pwm_n[i], 1'b0);
        end
        chk("period_start", 0, bus.period_start, m_ps);
        chk("update_pending", 0, bus.update_pending, m_pend);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
        s_load = 0;
        drive();
    endtask

    task automatic do_load();
        s_load = 1;
        drive();
        cycle();
    endtask

    task automatic measure(input int ncyc, input int ch, output int ph, output int nh,
                           output int bl, output int ps);
        ph = 0; nh = 0; bl = 0; ps = 0;
        for (int k = 0; k < ncyc; k++) begin
            cycle();
            ph += int'(bus.pwm_p[ch]);
            nh += int'(bus.pwm_n[ch]);
            bl += int'(!bus.pwm_p[ch] && !bus.pwm_n[ch]);
            ps += int'(bus.period_start);
        end
    endtask

    task automatic rand_cfg();
        s_per = $urandom_range(2, 12);
        s_pre = $urandom_range(0, 2);
        for (int i = 0; i < CH; i++) s_duty[i] = $urandom_range(0, s_per + 2);
    endtask

    task automatic mid_reset();
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < CH; i++) begin
            chk("rst_async_p", i, bus.pwm_p[i], 1'b0);
            chk("rst_async_n", i, bus.pwm_n[i], 1'b0);
        end
        chk("rst_async_ps", 0, bus.period_start, 1'b0);
        chk("rst_async_pending", 0, bus.update_pending, 1'b0);
        model_reset();
        cycle();
        cycle();
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int ph, nh, bl, ps;
        bit found;
        for (int i = 0; i < CH; i++) s_duty[i] = 0;
        model_reset();
        drive();
        #1;
        // reset state
        for (int i = 0; i < CH; i++) begin
            chk("reset_p", i, bus.pwm_p[i], 1'b0);
            chk("reset_n", i, bus.pwm_n[i], 1'b0);
        end
        chk("reset_ps", 0, bus.period_start, 1'b0);
        chk("reset_pending", 0, bus.update_pending, 1'b0);
        cycle(); cycle();
        rst_n = 1;

        // basic duty 3 of 10, plus 0% and 100% channels
        s_per = 9; s_pre = 0; s_dt = 0;
        s_duty[0] = 3; s_duty[1] = 10; s_duty[2] = 4; s_duty[3] = 0;
        s_en = 1;
        do_load();
        repeat (30) cycle();
        measure(10, 0, ph, nh, bl, ps);
        chk_int("t1_p0_high", ph, 3);
        chk_int("t1_n0_high", nh, 7);
        chk_int("t1_period_start", ps, 1);
        measure(10, 1, ph, nh, bl, ps);
        chk_int("t1_p1_full", ph, 10);
        chk_int("t1_n1_full", nh, 0);

        // duty 0 loaded while running
        s_duty[0] = 0;
        do_load();
        repeat (25) cycle();
        measure(10, 0, ph, nh, bl, ps);
        chk_int("t2_p0_zero", ph, 0);
        chk_int("t2_n0_full", nh, 10);

        // dead time 3 with 50% duty
        s_en = 0; drive(); cycle();
        s_dt = 3; s_duty[0] = 5;
        do_load();
        s_en = 1; drive();
        repeat (30) cycle();
        measure(10, 0, ph, nh, bl, ps);
        chk_int("t3_both_low", bl, 6);
        chk_int("t3_p0_high", ph, 2);
        chk_int("t3_n0_high", nh, 2);

        // prescaler 2, period 3
        s_en = 0; drive(); cycle();
        s_dt = 0; s_pre = 2; s_per = 3; s_duty[0] = 2;
        do_load();
        s_en = 1; drive();
        repeat (40) cycle();
        measure(12, 0, ph, nh, bl, ps);
        chk_int("t4_p0_high", ph, 6);
        chk_int("t4_period_start", ps, 1);

        // load in the middle of a period
        s_en = 0; drive(); cycle();
        s_pre = 0; s_per = 9; s_duty[0] = 3;
        do_load();
        s_en = 1; drive();
        repeat (15) cycle();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            found = (m_c == 4);
        end
        chk("t5_reach_cnt4", 0, found, 1'b1);
        s_duty[0] = 7;
        do_load();
        chk("t5_pending_set", 0, bus.update_pending, 1'b1);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            found = bus.period_start;
        end
        chk("t5_wrap_seen", 0, found, 1'b1);
        chk("t5_pending_clear", 0, bus.update_pending, 1'b0);
        repeat (10) cycle();
        measure(10, 0, ph, nh, bl, ps);
        chk_int("t5_p0_high", ph, 7);

        // enable dropped while high side is on, then re-enabled
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            found = bus.pwm_p[0];
        end
        chk("t6_p0_on", 0, found, 1'b1);
        s_en = 0; drive(); cycle();
        chk("t6_off_p", 0, bus.pwm_p[0], 1'b0);
        chk("t6_off_n", 0, bus.pwm_n[0], 1'b0);
        s_duty[0] = 4;
        do_load();
        chk("t6_pending_disabled", 0, bus.update_pending, 1'b1);
        s_en = 1; drive();
        measure(10, 0, ph, nh, bl, ps);
        chk_int("t6_single_start", ps, 1);

        // randomized segments; dead time only changes while disabled
        for (int seg = 0; seg < 24; seg++) begin
            s_en = 0; drive(); cycle(); cycle();
            s_dt = $urandom_range(0, 3);
            rand_cfg();
            do_load();
            s_en = 1; drive();
            for (int k = 0; k < 50; k++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 8) begin
                    rand_cfg();
                    s_load = 1;
                end
                s_en = (r >= 8 && r < 11) ? 1'b0 : 1'b1;
                drive();
                cycle();
            end
            if (seg == 12) mid_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pwm_multi_deadtime.md
Name: pwm_multi_deadtime

Overview:
Next-generation PWM source for the motor/power stage. Drives CHANNELS independent duty cycles from one shared, programmable-period counter with a clock prescaler. Each channel has a complementary p/n output pair with programmable dead-time. Duty, period, prescale and dead-time changes are double-buffered so that they take effect only at a period boundary (glitch-free updates from the control side).

Parameters:
CHANNELS, 4, number of output pairs
RESOLUTION, 8, counter/period width in bits
PRESCALE_W, 8, prescaler setting width
DEADTIME_W, 4, dead-time setting width (clk cycles)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run control; low = outputs off, counter held
load  in  1  one-cycle pulse: capture duty/period/prescale/deadtime inputs into shadow
period  in  RESOLUTION  counter terminal value; period length = period+1 ticks
prescale  in  PRESCALE_W  tick every prescale+1 clk cycles
deadtime  in  DEADTIME_W  dead-time in clk cycles, applied per edge
duty  in  CHANNELS*(RESOLUTION+1)  packed per-channel duty; channel i at [i*(RESOLUTION+1) +: RESOLUTION+1]
pwm_p  out  CHANNELS  high-side drive
pwm_n  out  CHANNELS  low-side drive
period_start  out  1  one-cycle pulse when counter wraps to 0
update_pending  out  1  shadow holds values not yet applied

Behaviour:
- Reset (async, rst_n low): pwm_p=0, pwm_n=0, period_start=0, update_pending=0. Counter=0, prescaler=0. Active and shadow regs: duty=0, period=all ones, prescale=0, deadtime=0.
- Prescaler: counts 0..prescale_active. Tick asserts on the cycle it equals prescale_active, then wraps to 0. prescale=0 gives a tick every cycle.
- Counter: advances on tick. At counter==period_active with tick, it wraps to 0 and period_start pulses on the next cycle (registered).
- Raw compare per channel: raw_i = (counter < duty_active_i).
  - duty=0 gives constant low.
  - duty >= period+1 gives constant high (100% is reachable because duty has RESOLUTION+1 bits).
- Shadow/update:
  - load captures all inputs into shadow and sets update_pending.
  - At a wrap, if pending, active <= shadow and pending clears.
  - load on the same cycle as a wrap: the new inputs go directly to active; pending stays 0.
  - Repeated loads before a wrap: the last one wins.
- Dead-time FSM per channel, states OFF, P_ON, N_ON, DEAD:
  - OFF exists only after reset or while enable is low. Leaving OFF goes through DEAD toward the side selected by raw.
  - P_ON (p=1,n=0) with raw falling: go to DEAD with target N, timer=deadtime_active.
  - N_ON (p=0,n=1) with raw rising: go to DEAD with target P.
  - DEAD (p=0,n=0): timer decrements each clk; at 0, go to the target state.
  - raw reverses during DEAD: target flips, timer reloads; outputs stay low.
  - deadtime=0: DEAD lasts 0 cycles, so the output follows raw one clk after raw changes.
- Invariant: pwm_p & pwm_n never both 1 in any cycle, including reset, enable and update transitions.
- Latency: with deadtime=d, the output edge appears d+1 clk cycles after the raw edge.
- enable low:
  - All FSMs go to OFF next cycle (outputs 0).
  - Counter and prescaler are held at 0.
  - period_start=0.
  - load still works and the shadow is kept.
- enable rising:
  - Pending shadow values are applied immediately.
  - Counting starts from 0; period_start pulses once.
- Reset mid-operation: immediate return to reset values; no partial update survives.

Decomposition:
- Package pwm_pkg: state enum (OFF, P_ON, N_ON, DEAD), default constants for reset values, and a function to extract channel duty from the packed vector.
- Sub-module pwm_deadtime_ch: one FSM plus timer per channel, instantiated CHANNELS times via generate.
- Top level holds the prescaler, counter, shadow/active registers and compares.

Test Plan:
- Reset with enable=1, period=9, prescale=0, deadtime=0, duty0=3, load -> after the first wrap, pwm_p[0] high 3 of every 10 cycles; period_start every 10 cycles; pwm_n[0] is its complement.
- duty0=0 and duty1=10 with period=9 -> pwm_p[0] constantly 0 and pwm_n[0] constantly 1; pwm_p[1] constantly 1.
- deadtime=3, duty0=5, period=9 -> on every edge, both outputs low for exactly 3 cycles; the p/n overlap checker never fires.
- prescale=2, period=3 -> period_start every 12 clk cycles; duty=2 gives pwm_p high 6 cycles per period (deadtime 0).
- load duty0=7 mid-period (counter=4) -> the current period keeps the old duty; update_pending=1 until the wrap, then duty 7 applies from counter=0.
- enable dropped with pwm_p=1 -> both outputs 0 the next cycle; re-enable -> counter restarts at 0 and period_start pulses once.
